regfile_wb_scoreboard: RTL
==========================

# regfile_wb_scoreboard

Integer register file with a per-register pending-write scoreboard. It sits at the far end of the write-back path and consumes the registered write-back triple: write data, write enable and destination address. It serves the two decode-stage source reads with same-cycle write-back bypass. It tracks in-flight writes per destination so that decode stalls an instruction whose source operands are not yet written back.

## Interface
Parameters:
- XLEN, 32, data width of each register.
- CNT_W, 2, width of each per-register pending counter; max in-flight writes per register = 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- werf_in  input  1  write-back enable from the write-back pipeline register.
- write_addr_in  input  5  write-back destination register.
- write_data_in  input  XLEN  write-back data.
- rs1_addr, rs2_addr  input  5  decode source addresses.
- rs1_used, rs2_used  input  1  source actually read by the decoding instruction.
- issue_valid  input  1  decode stage presents an instruction this cycle.
- issue_wr  input  1  decoding instruction writes a destination.
- issue_rd  input  5  destination of the decoding instruction.
- rs1_data, rs2_data  output  XLEN  source operand values (combinational).
- stall  output  1  decode must hold; the issue is not accepted this cycle (combinational).
- busy  output  1  registered; 1 while any pending counter is nonzero.

## Operation
- Storage: x1..x31, XLEN bits each. x0 is not stored; it always reads 0, and writes to it are dropped.
- Write: at posedge, when werf_in=1 and write_addr_in≠0, regs[write_addr_in] ← write_data_in.
- Read rsN:
  - rsN_addr=0 → 0.
  - Else if werf_in=1 and write_addr_in=rsN_addr → write_data_in (bypass).
  - Else → regs[rsN_addr].
- Pending counters cnt[1..31]:
  - inc = issue_valid & issue_wr & issue_rd≠0 & ~stall, applied to cnt[issue_rd].
  - dec = werf_in & write_addr_in≠0, applied to cnt[write_addr_in].
  - inc and dec on the same index → unchanged.
  - dec with cnt=0 → stays 0 (no underflow). This is treated as a protocol error.
- Effective pending for source N: eff = cnt[rsN_addr], minus 1 if dec hits rsN_addr this cycle. eff is 0 when rsN_addr=0.
- hazN = rsN_used & (eff≠0).
- full = issue_wr & issue_rd≠0 & cnt[issue_rd]=max & ~(dec hits issue_rd).
- stall = issue_valid & (haz1 | haz2 | full).
- busy ← OR of all next-state counters, registered.

## Timing
- Reset (asynchronous, on assertion): regs x1..x31=0, all cnt=0, busy=0. Read outputs reflect the zeroed storage immediately.
- Reset released mid-operation: the first posedge after deassertion behaves as a normal cycle. Writes and issues present during reset are discarded.
- Write latency: data visible through the storage path from the posedge after werf_in. In the same cycle it is visible via the bypass (zero-cycle read-after-write).
- stall and rsN_data are purely combinational from current inputs and state; there is no registered stall.
- Counter update and busy are registered on posedge.
- Simultaneous write-back to rd and issue reading rd with cnt[rd]=1:
  - No stall.
  - Operand = write_data_in.
- Same case with cnt[rd]=2: stall, because an older writer is still outstanding.
- Issue with issue_rd=rs1_addr while rs1 is free: no stall. The counter increments after the read.

## Test plan
- Reset/x0:
  - Assert reset with prior nonzero contents → all reads 0, busy=0.
  - Write 0xDEADBEEF to x0 → rs1_addr=0 still reads 0.
- Write/read and bypass:
  - werf_in=1, addr=5, data=0x12345678 while rs1_addr=5 → rs1_data=0x12345678 in the same cycle.
  - With werf_in=0 next cycle → still 0x12345678.
- RAW stall:
  - Issue writing x7 (cnt=1).
  - Next cycle issue with rs2_used, rs2_addr=7 → stall=1.
  - Write-back to x7 with data 0xA5 in the same cycle as the retry → stall=0, rs2_data=0xA5; cnt[7] returns to 0, busy=0 next cycle.
- Unused source: rs1_addr=7 pending with rs1_used=0 → stall=0.
- WAW saturation:
  - Three issues writing x3 → cnt=3.
  - Fourth issue writing x3 → stall=1.
  - Same fourth issue with write-back to x3 in that cycle → stall=0, cnt stays 3.
- Async reset mid-flight:
  - cnt[9]=2 with a pending write-back.
  - Assert reset between edges → busy=0 and cnt cleared immediately.
  - The write-back presented during reset does not modify x9.

Source files
------------

// File: rtl/regfile_wb_scoreboard.sv
// regfile_wb_scoreboard: register file with write-back bypass and per-register pending-write scoreboard
module regfile_wb_scoreboard #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            werf_in,
  input  logic [4:0]      write_addr_in,
  input  logic [XLEN-1:0] write_data_in,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic            rs1_used,
  input  logic            rs2_used,
  input  logic            issue_valid,
  input  logic            issue_wr,
  input  logic [4:0]      issue_rd,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            stall,
  output logic            busy
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [XLEN-1:0]  regs    [32];
  logic [CNT_W-1:0] cnt     [32];
  logic [CNT_W-1:0] cnt_nxt [32];
  logic dec, inc, full, haz1, haz2, hit1, hit2, hit_rd, any_nxt;
  assign dec    = werf_in && write_addr_in != 5'd0;
  assign hit1   = dec && write_addr_in == rs1_addr;
  assign hit2   = dec && write_addr_in == rs2_addr;
  assign hit_rd = dec && write_addr_in == issue_rd;
  assign rs1_data = rs1_addr == 5'd0 ? '0 : hit1 ? write_data_in : regs[rs1_addr];
  assign rs2_data = rs2_addr == 5'd0 ? '0 : hit2 ? write_data_in : regs[rs2_addr];
  // Entry 0 never counts, so x0 sources never raise a hazard.
  assign haz1  = rs1_used && cnt[rs1_addr] != '0 && !(hit1 && cnt[rs1_addr] == CNT_W'(1));
  assign haz2  = rs2_used && cnt[rs2_addr] != '0 && !(hit2 && cnt[rs2_addr] == CNT_W'(1));
  assign full  = issue_wr && issue_rd != 5'd0 && cnt[issue_rd] == CNT_MAX && !hit_rd;
  assign stall = issue_valid && (haz1 || haz2 || full);
  assign inc   = issue_valid && issue_wr && issue_rd != 5'd0 && !stall;
  always_comb begin
    any_nxt = 1'b0;
    for (int i = 0; i < 32; i++) begin
      cnt_nxt[i] = (inc && issue_rd == 5'(i)) && !(dec && write_addr_in == 5'(i)) ? cnt[i] + CNT_W'(1) :
                   (dec && write_addr_in == 5'(i)) && !(inc && issue_rd == 5'(i)) && cnt[i] != '0 ? cnt[i] - CNT_W'(1) :
                   cnt[i];
      any_nxt = any_nxt || cnt_nxt[i] != '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      busy <= 1'b0;
    end else begin
      if (dec) regs[write_addr_in] <= write_data_in;
      for (int i = 0; i < 32; i++) cnt[i] <= cnt_nxt[i];
      busy <= any_nxt;
    end
  end
endmodule
